// File: rtl/datamem_responder.sv
`default_nettype none
//==============================================================================
// Module      : datamem_responder
// Description : Multi-cycle, byte-addressed, little-endian data memory that
//               serves MEM-stage load/store requests over a valid/ready
//               request channel and a valid/ready response channel. Every
//               request is checked for size, alignment and range; rejected
//               requests return resp_err=1 with no memory access.
// Ports       : clk         - clock, all state changes on posedge
//               reset       - asynchronous, active-high reset
//               req_valid   - request present
//               req_ready   - responder can accept a request (registered)
//               req_write   - 1 = store, 0 = load
//               req_addr    - 64-bit byte address
//               req_wdata   - store data, low req_size bytes used
//               req_size    - one-hot size: 0001=1B 0010=2B 0100=4B 1000=8B
//               resp_valid  - response present (registered)
//               resp_ready  - consumer accepts the response
//               resp_rdata  - zero-extended load data, 0 for stores/errors
//               resp_err    - request rejected, no access took place
// Revision    : 1.0 - initial release
//==============================================================================
module datamem_responder #(
    parameter int DEPTH_BYTES = 1024,  // power of 2, >= 8
    parameter int LATENCY     = 3      // >= 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int c_ADDR_W = $clog2(DEPTH_BYTES);
    localparam int c_CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_write;
    logic [63:0]          r_addr;
    logic [63:0]          r_wdata;
    logic [3:0]           r_size;
    logic                 r_req_ready;
    logic                 r_resp_valid;
    logic [63:0]          r_resp_rdata;
    logic                 r_resp_err;

    // Storage is deliberately not reset.
    logic [7:0]           r_mem [0:DEPTH_BYTES-1];

    logic                 w_accept;
    logic                 w_enter_resp;
    logic                 w_acc_write;
    logic [63:0]          w_acc_addr;
    logic [63:0]          w_acc_wdata;
    logic [3:0]           w_acc_size;
    logic                 w_onehot;
    logic                 w_misalign;
    logic [64:0]          w_end;
    logic                 w_range;
    logic                 w_err;
    logic [c_ADDR_W-1:0]  w_idx [8];
    logic [7:0]           w_ben;
    logic [63:0]          w_rdata;

    assign w_accept = (r_state == S_IDLE) && req_valid;

    // With LATENCY=1 the access happens on the accept edge itself, so the
    // live request inputs are used; otherwise the latched copy is used.
    assign w_enter_resp = ((LATENCY == 1) && w_accept) ||
                          ((r_state == S_BUSY) && (r_cnt == c_CNT_W'(1)));

    assign w_acc_write = (r_state == S_IDLE) ? req_write : r_write;
    assign w_acc_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_acc_size  = (r_state == S_IDLE) ? req_size  : r_size;

    // A one-hot size code is numerically equal to its byte count.
    always_comb begin
        w_onehot = 1'b0;
        case (w_acc_size)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_onehot = 1'b1;
            default:                            w_onehot = 1'b0;
        endcase
    end

    assign w_misalign = |(w_acc_addr[3:0] & (w_acc_size - 4'd1));
    // 65-bit sum so an address near 2^64 cannot wrap back into range.
    assign w_end      = {1'b0, w_acc_addr} + 65'(w_acc_size);
    assign w_range    = w_end > 65'(DEPTH_BYTES);
    assign w_err      = !w_onehot || w_misalign || w_range;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_idx[k] = w_acc_addr[c_ADDR_W-1:0] + c_ADDR_W'(k);
            w_ben[k] = (4'(k) < w_acc_size);
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < 8; k++) begin
            if (w_ben[k]) begin
                w_rdata[8*k +: 8] = r_mem[w_idx[k]];
            end
        end
    end

    // Store commit; gated by reset so an aborted request never lands.
    always_ff @(posedge clk) begin
        if (!reset && w_enter_resp && w_acc_write && !w_err) begin
            for (int k = 0; k < 8; k++) begin
                if (w_ben[k]) begin
                    r_mem[w_idx[k]] <= w_acc_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_size      <= req_size;
                        r_cnt       <= c_CNT_W'(LATENCY - 1);
                        r_req_ready <= 1'b0;
                        r_state     <= (LATENCY == 1) ? S_RESP : S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase

            if (w_enter_resp) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_err;
                r_resp_rdata <= (w_acc_write || w_err) ? 64'd0 : w_rdata;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_datamem_responder.sv
`default_nettype none
//==============================================================================
// Module      : tb_datamem_responder
// Description : Self-checking bench for datamem_responder. A LATENCY=3
//               instance runs a table of directed load/store vectors plus
//               back-pressure and mid-request reset sequences; a LATENCY=1
//               instance runs back-to-back requests.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_datamem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_size = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [63:0] resp_rdata;

    logic        req_valid1 = 1'b0, req_write1 = 1'b0, resp_ready1 = 1'b1;
    logic [63:0] req_addr1 = '0, req_wdata1 = '0;
    logic [3:0]  req_size1 = '0;
    logic        req_ready1, resp_valid1, resp_err1;
    logic [63:0] resp_rdata1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    datamem_responder #(.DEPTH_BYTES(1024), .LATENCY(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    datamem_responder #(.DEPTH_BYTES(1024), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_size(req_size1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Accept and response never overlap on either instance.
    always @(negedge clk) begin
        if (!reset) begin
            chk("ready_valid_overlap", 64'(req_ready && resp_valid), 64'd0);
            chk("ready_valid_overlap1", 64'(req_ready1 && resp_valid1), 64'd0);
        end
    end

    // Called at posedge+#1. Returns the response and the accept-to-response
    // edge count (accept edge counted as 1); lat=0 means it never arrived.
    task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                       input logic [3:0] s, output logic [63:0] rd,
                       output logic er, output int lat);
        int n;
        req_write = w; req_addr = a; req_wdata = d; req_size = s; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_before_accept", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Fields are latched at accept; trash them to prove it.
        req_write = ~w; req_addr = '1; req_wdata = 64'h5A5A_5A5A_5A5A_5A5A; req_size = 4'b0000;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!resp_valid) begin
            lat = 0;
            chk("resp_timeout", 64'(resp_valid), 64'd1);
        end
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  size;
        logic [63:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        logic [63:0] held;

        vecs[0]  = '{1'b1, 64'h10,  64'h1122334455667788, 4'b1000, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, 64'h10,  64'h0, 4'b1000, 64'h1122334455667788, 1'b0};
        vecs[2]  = '{1'b1, 64'h13,  64'h123456789ABCDEAA, 4'b0001, 64'h0, 1'b0};
        vecs[3]  = '{1'b0, 64'h10,  64'h0, 4'b0100, 64'h00000000AA667788, 1'b0};
        vecs[4]  = '{1'b0, 64'h16,  64'h0, 4'b0010, 64'h1122, 1'b0};
        vecs[5]  = '{1'b1, 64'h3F8, 64'h0102030405060708, 4'b1000, 64'h0, 1'b0};
        vecs[6]  = '{1'b0, 64'h3FC, 64'h0, 4'b0100, 64'h01020304, 1'b0};
        vecs[7]  = '{1'b0, 64'h12,  64'h0, 4'b0100, 64'h0, 1'b1};
        vecs[8]  = '{1'b0, 64'h10,  64'h0, 4'b0011, 64'h0, 1'b1};
        vecs[9]  = '{1'b0, 64'h3FC, 64'h0, 4'b1000, 64'h0, 1'b1};
        vecs[10] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEADBEEFDEADBEEF, 4'b1000, 64'h0, 1'b1};
        vecs[11] = '{1'b1, 64'h11,  64'hFFFF, 4'b0010, 64'h0, 1'b1};
        vecs[12] = '{1'b1, 64'h400, 64'hCAFE, 4'b1000, 64'h0, 1'b1};
        vecs[13] = '{1'b1, 64'h18,  64'hBEEF, 4'b0000, 64'h0, 1'b1};
        vecs[14] = '{1'b0, 64'h3F8, 64'h0, 4'b1000, 64'h0102030405060708, 1'b0};
        vecs[15] = '{1'b0, 64'h10,  64'h0, 4'b1000, 64'h11223344AA667788, 1'b0};
        vecs[16] = '{1'b0, 64'h17,  64'h0, 4'b0001, 64'h11, 1'b0};

        // Reset state, asserted asynchronously before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_req_ready1", 64'(req_ready1), 64'd1);
        chk("rst_resp_valid1", 64'(resp_valid1), 64'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vector table.
        for (int i = 0; i < NV; i++) begin
            txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size, rd, er, lat);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
            chk($sformatf("v%0d_idle_ready", i), 64'(req_ready), 64'd1);
            chk($sformatf("v%0d_resp_dropped", i), 64'(resp_valid), 64'd0);
        end

        // Back-pressure: response held for 5 cycles with resp_ready low.
        resp_ready = 1'b0;
        req_write = 1'b0; req_addr = 64'h10; req_size = 4'b1000; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp_latency", 64'(lat), 64'd3);
        held = 64'h11223344AA667788;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_valid", c), 64'(resp_valid), 64'd1);
            chk($sformatf("bp%0d_rdata", c), resp_rdata, held);
            chk($sformatf("bp%0d_err", c), 64'(resp_err), 64'd0);
            chk($sformatf("bp%0d_req_ready", c), 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(resp_valid), 64'd0);
        chk("bp_release_rdata", resp_rdata, 64'd0);
        chk("bp_release_ready", 64'(req_ready), 64'd1);

        // Reset one cycle into BUSY aborts the store.
        txn(1'b1, 64'h20, 64'h1, 4'b1000, rd, er, lat);
        chk("t5_prior_err", 64'(er), 64'd0);
        req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'hDEAD; req_size = 4'b1000;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("t5_busy_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("t5_async_ready", 64'(req_ready), 64'd1);
        chk("t5_async_valid", 64'(resp_valid), 64'd0);
        chk("t5_async_rdata", resp_rdata, 64'd0);
        chk("t5_async_err", 64'(resp_err), 64'd0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        txn(1'b0, 64'h20, 64'h0, 4'b1000, rd, er, lat);
        chk("t5_load_after_abort", rd, 64'h1);
        chk("t5_load_err", 64'(er), 64'd0);

        // LATENCY=1: back-to-back stores with req_valid held high.
        req_write1 = 1'b1; req_addr1 = 64'h40; req_wdata1 = 64'h0F1E2D3C4B5A6978;
        req_size1 = 4'b1000; resp_ready1 = 1'b1;
        req_valid1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk($sformatf("t6_%0d_resp_valid", i), 64'(resp_valid1), 64'((i % 2) == 0));
            chk($sformatf("t6_%0d_req_ready", i), 64'(req_ready1), 64'((i % 2) == 1));
            chk($sformatf("t6_%0d_err", i), 64'(resp_err1), 64'd0);
        end
        // Switch the held request to a load; it is accepted on the next edge.
        req_write1 = 1'b0;
        @(posedge clk); #1;
        chk("t6_load_valid", 64'(resp_valid1), 64'd1);
        chk("t6_load_rdata", resp_rdata1, 64'h0F1E2D3C4B5A6978);
        req_valid1 = 1'b0;
        @(posedge clk); #1;
        chk("t6_final_idle", 64'(req_ready1), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
